// File: rtl/cam_capture_ctrl.sv
// Camera write-side sequencer: samples an OV7670-style bus, packs RGB565 byte
// pairs into RGB332 pixels and writes one frame into the frame buffer.
module cam_capture_ctrl #(
  parameter int unsigned AW    = 15,
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 160,
  parameter int unsigned IMG_H = 120
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  input  logic          capture_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  output logic          frame_done,
  output logic          busy,
  output logic          line_err
);

  localparam int unsigned CW = $clog2(IMG_W + 1);
  localparam int unsigned RW = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H);
  localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    CAPTURE,
    DONE
  } state_t;

  state_t state, state_nx;

  // [0],[1] form the synchroniser, [2] is the previous synchronised value
  logic [2:0] pclk_sr, href_sr, vsync_sr;
  logic [7:0] data_s1, data_s2;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;
  logic          phase;
  logic [5:0]    b1_bits;

  logic pclk_rise, byte_acc, href_fall, vsync_fall, vsync_rise, phase_after;
  logic [7:0] pixel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_s1  <= '0;
      data_s2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], cam_pclk};
      href_sr  <= {href_sr[1:0], cam_href};
      vsync_sr <= {vsync_sr[1:0], cam_vsync};
      data_s1  <= cam_data;
      data_s2  <= data_s1;
    end
  end

  assign pclk_rise   = pclk_sr[1] & ~pclk_sr[2];
  assign byte_acc    = pclk_rise & href_sr[1];
  assign href_fall   = href_sr[2] & ~href_sr[1];
  assign vsync_fall  = vsync_sr[2] & ~vsync_sr[1];
  assign vsync_rise  = vsync_sr[1] & ~vsync_sr[2];
  assign phase_after = byte_acc ? ~phase : phase;
  assign pixel       = {b1_bits, data_s2[4:3]};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (capture_en) state_nx = WAIT_VS;
      WAIT_VS: if (vsync_fall) state_nx = CAPTURE;
      CAPTURE: if (vsync_rise) state_nx = DONE;
      DONE:    state_nx = capture_en ? WAIT_VS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pixel packing, address generation and status flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      line_err   <= 1'b0;
      col        <= '0;
      row        <= '0;
      row_base   <= '0;
      phase      <= 1'b0;
      b1_bits    <= '0;
    end else begin
      mem_wr     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        WAIT_VS: begin
          if (vsync_fall) begin
            busy     <= 1'b1;
            line_err <= 1'b0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
            phase    <= 1'b0;
          end
        end
        CAPTURE: begin
          if (byte_acc) begin
            if (!phase) begin
              b1_bits <= {data_s2[7:5], data_s2[2:0]};
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (col < COL_MAX) begin
                col <= col + CW'(1);
                if (row < ROW_MAX) begin
                  mem_wr   <= 1'b1;
                  mem_addr <= row_base + AW'(col);
                  mem_data <= DW'(pixel);
                end
              end
            end
          end
          // Line end runs after any byte accepted in the same cycle
          if (href_fall) begin
            if (phase_after) line_err <= 1'b1;
            if (row < ROW_MAX) begin
              row_base <= row_base + ROW_STEP;
              row      <= row + RW'(1);
            end
            col   <= '0;
            phase <= 1'b0;
          end
          if (vsync_rise) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scoreboard bench for cam_capture_ctrl on a reduced 16x10 geometry.
module tb_cam_capture_ctrl;

  localparam int unsigned TB_W  = 16;
  localparam int unsigned TB_H  = 10;
  localparam int unsigned TB_AW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cam_pclk, cam_vsync, cam_href, capture_en;
  logic [7:0]       cam_data;
  logic [TB_AW-1:0] mem_addr;
  logic [7:0]       mem_data;
  logic             mem_wr, frame_done, busy, line_err;

  cam_capture_ctrl #(.AW(TB_AW), .DW(8), .IMG_W(TB_W), .IMG_H(TB_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .capture_en (capture_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wr     (mem_wr),
    .frame_done (frame_done),
    .busy       (busy),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  int         exp_addr_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] fixed_q[$];
  int         lens[$];
  logic [7:0] frame_data[$];
  int         frame_addr[$];

  int row     = 0;
  int exp_wr  = 0;
  int act_wr  = 0;
  int exp_done = 0;
  int act_done = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rgb332(input logic [7:0] b1, input logic [7:0] b2);
    return {b1[7:5], b1[2:0], b2[4:3]};
  endfunction

  // Monitor: every write strobe pops one expected pixel
  int         pop_a;
  logic [7:0] pop_d;
  always @(posedge clk) begin
    #1;
    if (mem_wr === 1'b1) begin
      act_wr++;
      frame_data.push_back(mem_data);
      frame_addr.push_back(int'(mem_addr));
      if (exp_addr_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %02h expected no write", mem_addr, mem_data);
      end else begin
        pop_a = exp_addr_q.pop_front();
        pop_d = exp_data_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(pop_a));
        chk("wr_data", 32'(mem_data), 32'(pop_d));
      end
    end
    if (frame_done === 1'b1) act_done++;
  end

  task automatic drive_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // mode 0: normal line end, 1: vsync rises mid-line, 2: leave line open
  task automatic send_line(input int nbytes, input bit cap, input int mode);
    logic [7:0] b, b1;
    int pix;
    b1 = 8'h00;
    pix = 0;
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_href = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      if (fixed_q.size() > 0) b = fixed_q.pop_front();
      else                    b = 8'($urandom);
      if (i % 2 == 0) b1 = b;
      else begin
        if (cap && pix < int'(TB_W) && row < int'(TB_H)) begin
          exp_addr_q.push_back(row * int'(TB_W) + pix);
          exp_data_q.push_back(rgb332(b1, b));
          exp_wr++;
        end
        pix++;
      end
      drive_byte(b);
    end
    if (mode == 0) begin
      if (cap && (nbytes % 2 == 1)) exp_err = 1'b1;
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      repeat (4) @(negedge clk);
      row++;
    end else if (mode == 1) begin
      cam_vsync = 1'b1;
      repeat (4) @(negedge clk);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic start_frame(input bit cap);
    row = 0;
    if (cap) exp_err = 1'b0;
    frame_data.delete();
    frame_addr.delete();
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (6) @(negedge clk);
    chk("busy_at_start", 32'(busy), 32'(cap));
    chk("line_err_at_start", 32'(line_err), 32'(exp_err));
  endtask

  task automatic run_frame(input bit cap, input bit vs_mid_last);
    start_frame(cap);
    for (int i = 0; i < lens.size(); i++)
      send_line(lens[i], cap, (vs_mid_last && i == lens.size() - 1) ? 1 : 0);
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    if (cap) exp_done++;
    chk("frame_done_count", 32'(act_done), 32'(exp_done));
    chk("busy_after_frame", 32'(busy), 32'(0));
    chk("line_err_after_frame", 32'(line_err), 32'(exp_err));
    chk("write_count", 32'(act_wr), 32'(exp_wr));
    chk("pending_writes", 32'(exp_addr_q.size()), 32'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    capture_en = 1'b0;
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    cam_data = 8'h00;
    // Reset with a noisy camera bus
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cam_pclk  = 1'($urandom);
      cam_href  = 1'($urandom);
      cam_vsync = 1'($urandom);
      cam_data  = 8'($urandom);
    end
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_data", 32'(mem_data), 32'(0));
    chk("rst_mem_wr", 32'(mem_wr), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_line_err", 32'(line_err), 32'(0));
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    // Capture disabled for a whole frame
    lens = {32, 32, 32};
    run_frame(1'b0, 1'b0);

    // Full frame plus two lines beyond the stored height
    capture_en = 1'b1;
    repeat (3) @(negedge clk);
    lens.delete();
    for (int i = 0; i < int'(TB_H) + 2; i++) lens.push_back(2 * int'(TB_W));
    run_frame(1'b1, 1'b0);
    chk("full_frame_writes", 32'(frame_addr.size()), 32'(TB_W * TB_H));
    chk("full_frame_last_addr", 32'(frame_addr[frame_addr.size() - 1]), 32'(TB_W * TB_H - 1));

    // Packing of fixed colour pairs
    fixed_q = {8'hF8, 8'h1F, 8'h07, 8'hE0};
    lens = {32, 32};
    run_frame(1'b1, 1'b0);
    chk("pack_f8_1f", 32'(frame_data[0]), 32'(8'hE3));
    chk("pack_07_e0", 32'(frame_data[1]), 32'(8'h1C));

    // Short line then long line
    lens = {20, 40, 32};
    run_frame(1'b1, 1'b0);
    chk("long_line_first_addr", 32'(frame_addr[10]), 32'(TB_W));
    chk("third_line_first_addr", 32'(frame_addr[26]), 32'(2 * TB_W));

    // Odd byte counts set the sticky error
    lens = {33, 32, 21};
    run_frame(1'b1, 1'b0);
    chk("odd_line_err_held", 32'(line_err), 32'(1));

    // vsync rising mid-line ends the frame, half pair dropped
    lens = {32, 5};
    run_frame(1'b1, 1'b1);

    // Reset in the middle of a frame
    start_frame(1'b1);
    for (int i = 0; i < 5; i++) send_line(32, 1'b1, 0);
    send_line(10, 1'b1, 2);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_pending", 32'(exp_addr_q.size()), 32'(0));
    cam_href = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_done", 32'(act_done), 32'(exp_done));
    lens = {32, 32, 32};
    run_frame(1'b1, 1'b0);
    chk("after_rst_first_addr", 32'(frame_addr[0]), 32'(0));

    // capture_en dropped mid-frame: frame completes, next one is ignored
    fork
      run_frame(1'b1, 1'b0);
      begin
        repeat (200) @(negedge clk);
        capture_en = 1'b0;
      end
    join
    run_frame(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Write-side sequencer for the dual-port frame buffer RAM. It samples the OV7670-style camera bus (pclk, href, vsync, 8-bit data) in the system clock domain. It packs each RGB565 byte pair into one RGB332 pixel and drives the buffer's write port (address, data, write strobe) so that one frame lands at addresses 0..IMG_W*IMG_H-1. The VGA read side is untouched; this block is the sole owner of the write port.

Parameters:
AW, 15, buffer address width; must satisfy 2**AW >= IMG_W*IMG_H
DW, 8, buffer data width; RGB332 pixel
IMG_W, 160, pixels stored per line
IMG_H, 120, lines stored per frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
cam_pclk  input  1  camera pixel clock, asynchronous, sampled
cam_vsync  input  1  camera frame sync, high between frames
cam_href  input  1  camera line valid
cam_data  input  8  camera byte bus
capture_en  input  1  continuous-capture enable
mem_addr  output  AW  buffer write address
mem_data  output  DW  buffer write data
mem_wr  output  1  buffer write strobe, one-cycle pulses
frame_done  output  1  one-cycle pulse at end of a captured frame
busy  output  1  high while a frame is being captured
line_err  output  1  sticky: odd byte count in a line; cleared at frame start

Behaviour:
- Reset (rst=0 at clk edge): mem_addr=0, mem_data=0, mem_wr=0, frame_done=0, busy=0, line_err=0. FSM goes to IDLE; byte phase, column, row and row-base counters are cleared. Reset mid-frame abandons the frame and produces no frame_done.
- Synchronisation: pclk, href and vsync each pass through a 2-flop synchroniser. cam_data passes through a matching 2-stage pipeline so it stays aligned with pclk.
- Byte sampling: a byte is accepted in the cycle where synchronised pclk is 0 in the previous cycle and 1 now, and synchronised href is 1.
- Input timing requirement: pclk high and low phases are each >= 2 clk periods.
- FSM states:
  - IDLE: go to WAIT_VS when capture_en=1.
  - WAIT_VS: wait for a synchronised vsync falling edge, then go to CAPTURE. On entry to CAPTURE: busy=1, line_err=0, counters cleared.
  - CAPTURE: on a synchronised vsync rising edge, go to DONE.
  - DONE: pulse frame_done for one cycle and set busy=0. Then go to WAIT_VS if capture_en=1, else IDLE.
- capture_en dropping mid-frame does not abort the frame; it only takes effect in DONE.
- Pixel packing:
  - First byte of a pair is b1, second is b2.
  - RGB332 pixel = {b1[7:5], b1[2:0], b2[4:3]}.
  - The pixel is written only if col < IMG_W and row < IMG_H.
- Write timing: mem_wr=1 for exactly one clk, in the cycle after b2 is accepted. mem_data and mem_addr are valid in that same cycle.
- Address: mem_addr = row_base + col, where row_base is an adder-maintained register (row*IMG_W; no multiplier).
- Column counting: col increments per completed pixel and saturates at IMG_W. Bytes beyond IMG_W pixels are discarded.
- Line end (synchronised href falling edge during CAPTURE):
  - If byte phase is odd: drop the half pixel and set line_err=1.
  - If row < IMG_H: row_base += IMG_W and row += 1.
  - col=0 and byte phase=0.
- Short line (fewer than IMG_W pixels): the remaining addresses of that row stay unwritten; the next line starts at the next row_base.
- Lines beyond IMG_H: bytes are still accepted but produce no writes.
- vsync rising edge mid-line is treated as the frame end; a partial pair is discarded.
- An href edge and a pclk edge arriving in the same cycle: the byte is accepted first, then the line-end handling is applied.
- Between writes, mem_wr=0. mem_addr and mem_data hold their last values.

Test Plan:
- Reset: hold rst=0 for 3 clk with random camera bus activity -> all outputs 0, no mem_wr.
- Full frame: capture_en=1, vsync fall, 120 lines of 320 bytes with pclk = clk/4 -> exactly 19200 mem_wr pulses at addresses 0..19199 in order, one frame_done after vsync rise, busy low afterward.
- Packing: pair b1=0xF8, b2=0x1F -> mem_data=0xE3. Pair b1=0x07, b2=0xE0 -> mem_data=0x1C.
- Short and long lines: line 0 with 100 pixels, line 1 with 200 pixels -> line 0 writes addresses 0..99, line 1 writes 160..319 only, line 2 starts at 320.
- Odd byte count: line of 321 bytes -> 160 writes, line_err=1 held until the next frame start.
- Reset mid-frame and disabled capture: rst=0 during line 50 -> no frame_done; the next frame starts at address 0 after a new vsync fall. With capture_en=0 for a whole frame -> zero writes.
